// File: rtl/button_conditioner_if.sv
// -----------------------------------------------------------------------------
// button_conditioner_if
//
// Purpose:
//   Bundles the board-side raw inputs and the conditioned outputs of the
//   button conditioner into one port.
//
// Signals:
//   btn_raw    [N_BTN]  raw buttons (asynchronous, active-high)
//   sw_raw     [1]      raw pass switch (asynchronous)
//   btn_level  [N_BTN]  debounced button levels
//   btn_pulse  [N_BTN]  one-cycle press pulses
//   sw_level   [1]      debounced pass-switch level
//   any_pulse  [1]      OR of btn_pulse, same cycle
//
// Modports:
//   master : drives the raw inputs and consumes the conditioned outputs
//   slave  : the conditioner itself
// -----------------------------------------------------------------------------
interface button_conditioner_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] btn_raw;
    logic             sw_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_pulse;
    logic             sw_level;
    logic             any_pulse;

    modport master (
        output btn_raw,
        output sw_raw,
        input  btn_level,
        input  btn_pulse,
        input  sw_level,
        input  any_pulse
    );

    modport slave (
        input  btn_raw,
        input  sw_raw,
        output btn_level,
        output btn_pulse,
        output sw_level,
        output any_pulse
    );
endinterface

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Purpose:
//   Front end for the cursor/move FSM. Every raw board button and the pass
//   switch are synchronised (two flops), debounced (a change is accepted only
//   after DEBOUNCE_CYCLES consecutive stable cycles) and, for the buttons,
//   edge-detected into single-cycle press pulses so that a held button cannot
//   re-trigger cursor moves or move submission.
//
//   Button bit map: [4]=up [3]=down [2]=left [1]=right [0]=make_move.
//
// Ports:
//   clk_in   in   system clock
//   reset    in   synchronous, active-high reset
//   bus      slave modport of button_conditioner_if
//              btn_raw/sw_raw in, btn_level/btn_pulse/sw_level/any_pulse out
//
// Parameters:
//   N_BTN            number of buttons
//   DEBOUNCE_CYCLES  consecutive stable cycles to accept a change (>= 2)
//   REPEAT_DELAY     hold cycles before the first auto-repeat pulse
//   REPEAT_PERIOD    cycles between later auto-repeat pulses
//   REPEAT_MASK      buttons allowed to auto-repeat (make_move excluded)
//
// Build option:
//   BTN_REPEAT_EN    when defined, masked buttons emit auto-repeat pulses
//                    while held. When undefined there is no repeat logic and
//                    each debounced press gives exactly one pulse; the
//                    REPEAT_* parameters are then ignored.
//
// Timing:
//   A raw change present before edge 1 and held shows up on btn_level (and,
//   for a press, on btn_pulse) after edge DEBOUNCE_CYCLES+2: two edges of
//   synchroniser, DEBOUNCE_CYCLES-1 counting edges, one accepting edge.
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int               N_BTN           = 5,
    parameter int               DEBOUNCE_CYCLES = 650000,
    parameter int               REPEAT_DELAY    = 32500000,
    parameter int               REPEAT_PERIOD   = 9750000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = 5'b11110
) (
    input  logic                 clk_in,
    input  logic                 reset,
    button_conditioner_if.slave  bus
);

    // Channels 0..N_BTN-1 are the buttons, channel N_BTN is the pass switch.
    localparam int N_CH = N_BTN + 1;
    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Two-flop synchroniser on every input
    // -------------------------------------------------------------------------
    logic [N_CH-1:0] raw_all;
    logic [N_CH-1:0] sync1_reg;
    logic [N_CH-1:0] sync2_reg;

    assign raw_all = {bus.sw_raw, bus.btn_raw};

    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw_all;
            sync2_reg <= sync1_reg;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce: per channel a counter of consecutive cycles in which the
    // synchronised input differs from the accepted level. Any cycle where
    // they agree again restarts the count, so bounce shorter than
    // DEBOUNCE_CYCLES can never flip the level. The counter is cleared when
    // it reaches its limit, so it never wraps.
    // -------------------------------------------------------------------------
    logic [N_CH-1:0] level_reg;
    logic [N_CH-1:0] level_next;
    logic [N_CH-1:0] db_done;    // change accepted at this edge
    logic [N_CH-1:0] rise_now;   // accepted change is a press
    logic [DB_W-1:0] cnt_reg  [N_CH];
    logic [DB_W-1:0] cnt_next [N_CH];

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_debounce
            logic differs;

            assign differs       = (sync2_reg[gi] != level_reg[gi]);
            assign db_done[gi]   = differs && (cnt_reg[gi] == DB_LAST);
            assign rise_now[gi]  = db_done[gi] & sync2_reg[gi];
            assign level_next[gi] = level_reg[gi] ^ db_done[gi];
            assign cnt_next[gi]  = (!differs || db_done[gi]) ? '0
                                                              : cnt_reg[gi] + 1'b1;

            always_ff @(posedge clk_in) begin
                if (reset) begin
                    cnt_reg[gi] <= '0;
                end else begin
                    cnt_reg[gi] <= cnt_next[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (reset) begin
            level_reg <= '0;
        end else begin
            level_reg <= level_next;
        end
    end

    // -------------------------------------------------------------------------
    // Pulse generation. pulse_next is evaluated at the same edge that accepts
    // the press, so the registered pulse and the new level appear together.
    // -------------------------------------------------------------------------
    logic [N_BTN-1:0] pulse_next;

`ifdef BTN_REPEAT_EN
    localparam int RP_W = (REPEAT_DELAY > 2) ? $clog2(REPEAT_DELAY) : 1;
    localparam logic [RP_W-1:0] RP_LAST   = RP_W'(REPEAT_DELAY - 1);
    // Reloading to DELAY-PERIOD makes the next terminal count PERIOD cycles
    // away, so one counter serves both the initial delay and the period.
    localparam logic [RP_W-1:0] RP_RELOAD = RP_W'(REPEAT_DELAY - REPEAT_PERIOD);

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_pulse
            if (REPEAT_MASK[gi]) begin : g_repeat
                logic [RP_W-1:0] rep_cnt_reg;
                logic            rep_fire;

                // No repeat pulse on the edge where the level is released.
                assign rep_fire = level_reg[gi] && !(db_done[gi] && !sync2_reg[gi])
                                  && (rep_cnt_reg == RP_LAST);
                assign pulse_next[gi] = rise_now[gi] | rep_fire;

                always_ff @(posedge clk_in) begin
                    if (reset || rise_now[gi] || !level_next[gi]) begin
                        rep_cnt_reg <= '0;
                    end else if (rep_fire) begin
                        rep_cnt_reg <= RP_RELOAD;
                    end else begin
                        rep_cnt_reg <= rep_cnt_reg + 1'b1;
                    end
                end
            end else begin : g_single
                assign pulse_next[gi] = rise_now[gi];
            end
        end
    endgenerate
`else
    assign pulse_next = rise_now[N_BTN-1:0];

    // Repeat configuration has no effect in this build.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_MASK, REPEAT_DELAY[0], REPEAT_PERIOD[0],
                                 rise_now[N_BTN]};
`endif

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    logic [N_BTN-1:0] btn_pulse_reg;
    logic             any_pulse_reg;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            btn_pulse_reg <= '0;
            any_pulse_reg <= 1'b0;
        end else begin
            btn_pulse_reg <= pulse_next;
            any_pulse_reg <= |pulse_next;
        end
    end

    assign bus.btn_level = level_reg[N_BTN-1:0];
    assign bus.sw_level  = level_reg[N_BTN];
    assign bus.btn_pulse = btn_pulse_reg;
    assign bus.any_pulse = any_pulse_reg;

endmodule

// File: tb/tb_button_conditioner.sv
`timescale 1ns/1ps
module tb_button_conditioner;

    localparam int N_BTN = 5;
    localparam int DB    = 4;
    localparam int RD    = 10;
    localparam int RP    = 3;
    localparam int LAT   = DB + 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    button_conditioner_if #(.N_BTN(N_BTN)) bus ();

    button_conditioner #(
        .N_BTN           (N_BTN),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .REPEAT_MASK     (5'b11110)
    ) dut (
        .clk_in (clk),
        .reset  (reset),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               at_edge;
        logic [N_BTN-1:0] vec;
    } pulse_exp_t;

    pulse_exp_t exp_q[$];
    int  edge_cnt = 0;
    int  checks   = 0;
    int  failures = 0;
    bit  mon_en   = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic push_exp(input int at, input logic [N_BTN-1:0] v);
        pulse_exp_t item;
        item.at_edge = at;
        item.vec     = v;
        exp_q.push_back(item);
    endtask

    // Scoreboard consumer: every pulse the DUT produces is matched against
    // the oldest expected pulse (edge number and vector).
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (bus.any_pulse !== (|bus.btn_pulse)) begin
                failures++;
                $display("FAIL any_pulse edge=%0d actual=%b required=%b",
                         edge_cnt, bus.any_pulse, |bus.btn_pulse);
            end
            while (exp_q.size() > 0 && exp_q[0].at_edge < edge_cnt) begin
                checks++;
                failures++;
                $display("FAIL missing_pulse edge=%0d actual=none required=%b at edge %0d",
                         edge_cnt, exp_q[0].vec, exp_q[0].at_edge);
                void'(exp_q.pop_front());
            end
            if (bus.btn_pulse !== '0) begin
                checks++;
                if (exp_q.size() > 0 && exp_q[0].at_edge == edge_cnt) begin
                    pulse_exp_t e;
                    e = exp_q.pop_front();
                    if (bus.btn_pulse !== e.vec) begin
                        failures++;
                        $display("FAIL pulse_vec edge=%0d actual=%b required=%b",
                                 edge_cnt, bus.btn_pulse, e.vec);
                    end else begin
                        $display("pulse edge=%0d vec=%b ok", edge_cnt, bus.btn_pulse);
                    end
                end else begin
                    failures++;
                    $display("FAIL unexpected_pulse edge=%0d actual=%b required=00000",
                             edge_cnt, bus.btn_pulse);
                end
            end
        end
    end

    task automatic test_reset();
        bus.btn_raw = '0;
        bus.sw_raw  = 1'b0;
        reset       = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.btn_level, bus.btn_pulse, bus.sw_level, bus.any_pulse} !== '0) begin
            failures++;
            $display("FAIL reset_outputs actual=%b required=0",
                     {bus.btn_level, bus.btn_pulse, bus.sw_level, bus.any_pulse});
        end
        mon_en = 1'b1;
        reset  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.btn_level, bus.btn_pulse, bus.sw_level, bus.any_pulse} !== '0) begin
                failures++;
                $display("FAIL idle_outputs edge=%0d actual=%b required=0", edge_cnt,
                         {bus.btn_level, bus.btn_pulse, bus.sw_level, bus.any_pulse});
            end
        end
        $display("test_reset done");
    endtask

    // Press a button pattern, hold it for hold_cycles, release it and watch
    // the level follow with the fixed debounce latency in both directions.
    task automatic test_press(input string name, input logic [N_BTN-1:0] pat,
                              input int hold_cycles);
        int e0;
        int e1;
        logic [N_BTN-1:0] exp_lvl;
        @(negedge clk);
        e0 = edge_cnt;
        bus.btn_raw = pat;
        push_exp(e0 + LAT, pat);
        $display("%s press %b at edge %0d", name, pat, e0);
        for (int k = 0; k < hold_cycles; k++) begin
            @(negedge clk);
            exp_lvl = (edge_cnt >= e0 + LAT) ? pat : '0;
            checks++;
            if (bus.btn_level !== exp_lvl) begin
                failures++;
                $display("FAIL %s_level_press edge=%0d actual=%b required=%b",
                         name, edge_cnt, bus.btn_level, exp_lvl);
            end
        end
        e1 = edge_cnt;
        bus.btn_raw = '0;
        $display("%s release at edge %0d", name, e1);
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            exp_lvl = (edge_cnt >= e1 + LAT) ? '0 : pat;
            checks++;
            if (bus.btn_level !== exp_lvl) begin
                failures++;
                $display("FAIL %s_level_release edge=%0d actual=%b required=%b",
                         name, edge_cnt, bus.btn_level, exp_lvl);
            end
        end
    endtask

    task automatic test_switch();
        int e0;
        int e1;
        logic exp_sw;
        @(negedge clk);
        e0 = edge_cnt;
        bus.sw_raw = 1'b1;
        $display("switch on at edge %0d", e0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_sw = (edge_cnt >= e0 + LAT);
            checks++;
            if (bus.sw_level !== exp_sw) begin
                failures++;
                $display("FAIL sw_level_on edge=%0d actual=%b required=%b",
                         edge_cnt, bus.sw_level, exp_sw);
            end
        end
        e1 = edge_cnt;
        bus.sw_raw = 1'b0;
        $display("switch off at edge %0d", e1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_sw = (edge_cnt < e1 + LAT);
            checks++;
            if (bus.sw_level !== exp_sw) begin
                failures++;
                $display("FAIL sw_level_off edge=%0d actual=%b required=%b",
                         edge_cnt, bus.sw_level, exp_sw);
            end
        end
    endtask

    task automatic test_bounce();
        logic pat [8];
        pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        $display("bounce on right button at edge %0d", edge_cnt);
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 8; j++) begin
                @(negedge clk);
                bus.btn_raw[1] = pat[j];
                checks++;
                if (bus.btn_level !== '0) begin
                    failures++;
                    $display("FAIL bounce_level edge=%0d actual=%b required=00000",
                             edge_cnt, bus.btn_level);
                end
            end
        end
        bus.btn_raw = '0;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            checks++;
            if (bus.btn_level !== '0) begin
                failures++;
                $display("FAIL bounce_settle edge=%0d actual=%b required=00000",
                         edge_cnt, bus.btn_level);
            end
        end
    endtask

    task automatic test_reset_mid();
        int e0;
        logic [N_BTN-1:0] exp_lvl;
        @(negedge clk);
        e0 = edge_cnt;
        bus.btn_raw = 5'b00001;
        // Reset samples only edge e0+4; re-debounce gives level at e0+4+LAT.
        push_exp(e0 + 4 + LAT, 5'b00001);
        $display("make_move held, reset pulse at edge %0d", e0 + 4);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({bus.btn_level, bus.btn_pulse, bus.any_pulse} !== '0) begin
            failures++;
            $display("FAIL reset_mid_clear edge=%0d actual=%b required=0", edge_cnt,
                     {bus.btn_level, bus.btn_pulse, bus.any_pulse});
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            exp_lvl = (edge_cnt >= e0 + 4 + LAT) ? 5'b00001 : 5'b00000;
            checks++;
            if (bus.btn_level !== exp_lvl) begin
                failures++;
                $display("FAIL reset_mid_level edge=%0d actual=%b required=%b",
                         edge_cnt, bus.btn_level, exp_lvl);
            end
        end
        bus.btn_raw = '0;
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic test_hold_repeat();
        int e0;
        logic [N_BTN-1:0] exp_lvl;
        @(negedge clk);
        e0 = edge_cnt;
        bus.btn_raw = 5'b01000;
        push_exp(e0 + LAT, 5'b01000);
`ifdef BTN_REPEAT_EN
        // Raw high for 30 cycles -> level falls at e0+30+LAT; repeats come
        // RD cycles after the press, then every RP cycles while still held.
        for (int t = e0 + LAT + RD; t < e0 + 30 + LAT; t += RP)
            push_exp(t, 5'b01000);
`endif
        $display("down held 30 cycles from edge %0d", e0);
        for (int k = 0; k < 30; k++) @(negedge clk);
        bus.btn_raw = '0;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            exp_lvl = (edge_cnt < e0 + 30 + LAT) ? 5'b01000 : 5'b00000;
            checks++;
            if (bus.btn_level !== exp_lvl) begin
                failures++;
                $display("FAIL hold_release_level edge=%0d actual=%b required=%b",
                         edge_cnt, bus.btn_level, exp_lvl);
            end
        end
        test_press("make_move_hold", 5'b00001, 30);
    endtask

    initial begin
        bus.btn_raw = '0;
        bus.sw_raw  = 1'b0;
        test_reset();
        test_press("up", 5'b10000, 8);
        test_switch();
        test_bounce();
        test_press("simultaneous", 5'b00011, 8);
        test_reset_mid();
        test_hold_repeat();
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL outstanding_pulses actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog edge=%0d actual=timeout required=finish", edge_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
